// File: rtl/data_mem_hs_pkg.sv
// Shared constants for the handshaked data memory: access lengths,
// exception codes, FSM states, the latched request bundle and the
// exception classifier used by the top level.
package data_mem_hs_pkg;

    // Access size codes (funct3-style DM encodings; code 3 behaves as WORD)
    typedef enum logic [1:0] {
        LEN_BYTE = 2'd0,
        LEN_HALF = 2'd1,
        LEN_WORD = 2'd2
    } len_e;

    typedef enum logic [1:0] {
        EXC_NONE     = 2'd0,
        EXC_MISALIGN = 2'd1,
        EXC_RANGE    = 2'd2
    } exc_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    // Request fields captured on the handshake
    typedef struct packed {
        logic        we;
        logic [1:0]  len;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    // Wide enough for LATENCY-1 with LATENCY up to 15
    localparam int CNT_W = 4;

    // Misalignment wins over range. The range compare is unsigned on the
    // wrapped offset, so addresses below the base land out of range.
    function automatic logic [1:0] calc_exc(
        input logic [1:0]  len,
        input logic [31:0] off,
        input logic [32:0] limit
    );
        logic mis;
        if (len == LEN_HALF) begin
            mis = off[0];
        end else if (len == LEN_BYTE) begin
            mis = 1'b0;
        end else begin
            mis = (off[1:0] != 2'b00);
        end
        if (mis) begin
            return EXC_MISALIGN;
        end
        if ({1'b0, off} >= limit) begin
            return EXC_RANGE;
        end
        return EXC_NONE;
    endfunction

endpackage

// File: rtl/data_mem_hs_lane_ext.sv
// Combinational byte-lane logic for the data memory.
// Ports:
//   rword_i  - current contents of the addressed word
//   len_i    - access size code
//   off_i    - byte offset within the word
//   uns_i    - 1 = zero-extend loads, 0 = sign-extend
//   wdata_i  - right-aligned store data
//   ldata_o  - extracted and extended load data
//   mword_o  - word with the store data merged into the selected lanes
module dm_lane_ext
    import data_mem_hs_pkg::*;
(
    input  logic [31:0] rword_i,
    input  logic [1:0]  len_i,
    input  logic [1:0]  off_i,
    input  logic        uns_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] ldata_o,
    output logic [31:0] mword_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [4:0]  byte_base;
    logic [4:0]  half_base;
    logic        ext_b;
    logic        ext_h;

    assign byte_base = {off_i, 3'b000};
    assign half_base = {off_i[1], 4'b0000};

    assign byte_sel = rword_i[byte_base +: 8];
    assign half_sel = rword_i[half_base +: 16];

    assign ext_b = ~uns_i & byte_sel[7];
    assign ext_h = ~uns_i & half_sel[15];

    always_comb begin
        ldata_o = rword_i;
        mword_o = wdata_i;
        unique case (1'b1)
            (len_i == LEN_BYTE): begin
                ldata_o = {{24{ext_b}}, byte_sel};
                mword_o = rword_i;
                mword_o[byte_base +: 8] = wdata_i[7:0];
            end
            (len_i == LEN_HALF): begin
                ldata_o = {{16{ext_h}}, half_sel};
                mword_o = rword_i;
                mword_o[half_base +: 16] = wdata_i[15:0];
            end
            default: begin
                ldata_o = rword_i;
                mword_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_hs.sv
// Single-port data memory with a valid/ready request channel and a
// one-cycle response pulse after a programmable latency.
// Ports:
//   Clk, reset                - clock, synchronous active-high reset
//   req_valid / req_ready     - request handshake (ready only when idle)
//   req_we, req_len           - store/load, access size
//   req_unsigned              - load zero-extend select
//   req_addr, req_wdata       - byte address, right-aligned store data
//   resp_valid                - one-cycle response strobe
//   resp_rdata, resp_exc      - load data and exception code
module data_mem_hs
    import data_mem_hs_pkg::*;
#(
    parameter int          DEPTH_WORDS = 3072,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          LATENCY     = 1
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_len,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_exc
);

    localparam int AW =
        (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] LIMIT = 33'(4 * DEPTH_WORDS);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    req_t               req_q, req_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [1:0]         exc_q, exc_d;

    logic [31:0]        mem_q [DEPTH_WORDS];

    logic [31:0]        off;
    logic [1:0]         exc;
    logic [AW-1:0]      idx;
    logic [31:0]        rword;
    logic [31:0]        ldata;
    logic [31:0]        mword;
    logic               fire;
    logic               mem_we;

    assign off = req_q.addr - BASE_ADDR;
    assign exc = calc_exc(req_q.len, off, LIMIT);
    assign idx = off[AW+1:2];

    // Index is only trusted when the access is legal; otherwise it may
    // point past the array, so the read is masked.
    assign rword = (exc == EXC_NONE) ? mem_q[idx] : '0;

    // Last WAIT cycle: memory is read/written on this edge
    assign fire   = (state_q == S_WAIT) && (cnt_q == '0);
    assign mem_we = fire && req_q.we && (exc == EXC_NONE);

    dm_lane_ext u_lane (
        .rword_i (rword),
        .len_i   (req_q.len),
        .off_i   (off[1:0]),
        .uns_i   (req_q.uns),
        .wdata_i (req_q.wdata),
        .ldata_o (ldata),
        .mword_o (mword)
    );

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_exc   = exc_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        exc_d   = exc_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d     = S_WAIT;
                    cnt_d       = CNT_W'(LATENCY - 1);
                    req_d.we    = req_we;
                    req_d.len   = req_len;
                    req_d.uns   = req_unsigned;
                    req_d.addr  = req_addr;
                    req_d.wdata = req_wdata;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                    exc_d   = exc;
                    if (!req_q.we && (exc == EXC_NONE)) begin
                        rdata_d = ldata;
                    end else begin
                        rdata_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            rdata_q <= '0;
            exc_q   <= EXC_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            exc_q   <= exc_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[idx] <= mword;
        end
    end

endmodule

// File: tb/tb_data_mem_hs.sv
// Directed bench for data_mem_hs: one instance at LATENCY=3 with base 0,
// one at LATENCY=1 with base 0x1000 and four words.
module tb_data_mem_hs;
    import data_mem_hs_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        va = 1'b0;
    logic        vb = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_len = 2'd0;
    logic        req_uns = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;

    logic        ready_a, ready_b;
    logic        rv_a, rv_b;
    logic [31:0] rd_a, rd_b;
    logic [1:0]  ex_a, ex_b;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    data_mem_hs #(
        .DEPTH_WORDS (64),
        .BASE_ADDR   (32'h0000_0000),
        .LATENCY     (3)
    ) u_a (
        .Clk          (clk),
        .reset        (rst),
        .req_valid    (va),
        .req_ready    (ready_a),
        .req_we       (req_we),
        .req_len      (req_len),
        .req_unsigned (req_uns),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (rv_a),
        .resp_rdata   (rd_a),
        .resp_exc     (ex_a)
    );

    data_mem_hs #(
        .DEPTH_WORDS (4),
        .BASE_ADDR   (32'h0000_1000),
        .LATENCY     (1)
    ) u_b (
        .Clk          (clk),
        .reset        (rst),
        .req_valid    (vb),
        .req_ready    (ready_b),
        .req_we       (req_we),
        .req_len      (req_len),
        .req_unsigned (req_uns),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (rv_b),
        .resp_rdata   (rd_b),
        .resp_exc     (ex_b)
    );

    // One request on instance sel; lat is counted in cycles from the
    // handshake cycle to the resp_valid cycle, 0 on timeout.
    task automatic access(
        input  bit          sel,
        input  logic        we,
        input  logic [1:0]  len,
        input  logic        uns,
        input  logic [31:0] addr,
        input  logic [31:0] wdata,
        output int          lat,
        output logic [31:0] rd,
        output logic [1:0]  ex
    );
        int k;
        @(negedge clk);
        k = 0;
        while (!(sel ? ready_b : ready_a) && k < 50) begin
            @(negedge clk);
            k++;
        end
        req_we = we;
        req_len = len;
        req_uns = uns;
        req_addr = addr;
        req_wdata = wdata;
        if (sel) vb = 1'b1;
        else va = 1'b1;
        @(posedge clk);
        #1;
        va = 1'b0;
        vb = 1'b0;
        // Scramble inputs; the latched request must be unaffected
        req_we = ~we;
        req_len = ~len;
        req_uns = ~uns;
        req_addr = 32'hFFFF_FFF3;
        req_wdata = 32'h5A5A_A5A5;
        lat = 0;
        rd = 'x;
        ex = 'x;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (sel ? rv_b : rv_a) begin
                lat = n + 1;
                rd = sel ? rd_b : rd_a;
                ex = sel ? ex_b : ex_a;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        vecs++;
        if (ready_a !== 1'b1 || ready_b !== 1'b1) begin
            errs++;
            $display("FAIL reset_ready got %b%b want 11",
                     ready_a, ready_b);
        end
        vecs++;
        if (rv_a !== 1'b0 || rv_b !== 1'b0) begin
            errs++;
            $display("FAIL reset_rvalid got %b%b want 00", rv_a, rv_b);
        end
        vecs++;
        if (rd_a !== 32'h0 || rd_b !== 32'h0) begin
            errs++;
            $display("FAIL reset_rdata got %h %h want 0", rd_a, rd_b);
        end
        vecs++;
        if (ex_a !== 2'd0 || ex_b !== 2'd0) begin
            errs++;
            $display("FAIL reset_exc got %0d %0d want 0", ex_a, ex_b);
        end
    endtask

    task automatic test_word();
        int lat;
        logic [31:0] rd;
        logic [1:0] ex;
        access(0, 1, LEN_WORD, 0, 32'h10, 32'h1234_5678, lat, rd, ex);
        vecs++;
        if (lat !== 4) begin
            errs++;
            $display("FAIL st_latency got %0d want 4", lat);
        end
        vecs++;
        if (ex !== 2'd0 || rd !== 32'h0) begin
            errs++;
            $display("FAIL st_word got exc=%0d rd=%h want 0 0", ex, rd);
        end
        access(0, 0, LEN_WORD, 0, 32'h10, 32'h0, lat, rd, ex);
        vecs++;
        if (rd !== 32'h1234_5678 || ex !== 2'd0 || lat !== 4) begin
            errs++;
            $display("FAIL ld_word got %h exc=%0d lat=%0d want 12345678 0 4",
                     rd, ex, lat);
        end
    endtask

    task automatic test_byte();
        int lat;
        logic [31:0] rd;
        logic [1:0] ex;
        access(0, 1, LEN_BYTE, 0, 32'h13, 32'hAAAA_AA80, lat, rd, ex);
        vecs++;
        if (ex !== 2'd0) begin
            errs++;
            $display("FAIL st_byte got exc=%0d want 0", ex);
        end
        access(0, 0, LEN_BYTE, 0, 32'h13, 32'h0, lat, rd, ex);
        vecs++;
        if (rd !== 32'hFFFF_FF80) begin
            errs++;
            $display("FAIL ld_byte_s got %h want ffffff80", rd);
        end
        access(0, 0, LEN_BYTE, 1, 32'h13, 32'h0, lat, rd, ex);
        vecs++;
        if (rd !== 32'h0000_0080) begin
            errs++;
            $display("FAIL ld_byte_u got %h want 00000080", rd);
        end
        access(0, 0, LEN_WORD, 0, 32'h10, 32'h0, lat, rd, ex);
        vecs++;
        if (rd !== 32'h8034_5678) begin
            errs++;
            $display("FAIL ld_word_merge got %h want 80345678", rd);
        end
    endtask

    task automatic test_half();
        int lat;
        logic [31:0] rd;
        logic [1:0] ex;
        access(0, 0, LEN_WORD, 0, 32'h12, 32'h0, lat, rd, ex);
        vecs++;
        if (ex !== 2'd1 || rd !== 32'h0) begin
            errs++;
            $display("FAIL ld_misalign got exc=%0d rd=%h want 1 0", ex, rd);
        end
        access(0, 1, LEN_HALF, 0, 32'h11, 32'h0000_FFFF, lat, rd, ex);
        vecs++;
        if (ex !== 2'd1) begin
            errs++;
            $display("FAIL st_misalign got exc=%0d want 1", ex);
        end
        access(0, 0, LEN_WORD, 0, 32'h10, 32'h0, lat, rd, ex);
        vecs++;
        if (rd !== 32'h8034_5678) begin
            errs++;
            $display("FAIL st_misalign_keep got %h want 80345678", rd);
        end
        access(0, 1, LEN_HALF, 0, 32'h12, 32'h1111_BEEF, lat, rd, ex);
        access(0, 0, LEN_WORD, 0, 32'h10, 32'h0, lat, rd, ex);
        vecs++;
        if (rd !== 32'hBEEF_5678) begin
            errs++;
            $display("FAIL st_half_hi got %h want beef5678", rd);
        end
        access(0, 0, LEN_HALF, 0, 32'h12, 32'h0, lat, rd, ex);
        vecs++;
        if (rd !== 32'hFFFF_BEEF) begin
            errs++;
            $display("FAIL ld_half_s got %h want ffffbeef", rd);
        end
        access(0, 0, LEN_HALF, 1, 32'h10, 32'h0, lat, rd, ex);
        vecs++;
        if (rd !== 32'h0000_5678) begin
            errs++;
            $display("FAIL ld_half_u got %h want 00005678", rd);
        end
        access(0, 0, LEN_BYTE, 0, 32'h11, 32'h0, lat, rd, ex);
        vecs++;
        if (rd !== 32'h0000_0056) begin
            errs++;
            $display("FAIL ld_byte1 got %h want 00000056", rd);
        end
    endtask

    task automatic test_range();
        int lat;
        logic [31:0] rd;
        logic [1:0] ex;
        access(1, 1, LEN_WORD, 0, 32'h1010, 32'h1, lat, rd, ex);
        vecs++;
        if (ex !== 2'd2 || lat !== 2) begin
            errs++;
            $display("FAIL st_range got exc=%0d lat=%0d want 2 2", ex, lat);
        end
        access(1, 0, LEN_WORD, 0, 32'h0FFC, 32'h0, lat, rd, ex);
        vecs++;
        if (ex !== 2'd2 || rd !== 32'h0) begin
            errs++;
            $display("FAIL ld_below got exc=%0d rd=%h want 2 0", ex, rd);
        end
        access(1, 0, LEN_WORD, 0, 32'h100C, 32'h0, lat, rd, ex);
        vecs++;
        if (ex !== 2'd0 || rd !== 32'h0) begin
            errs++;
            $display("FAIL ld_top got exc=%0d rd=%h want 0 0", ex, rd);
        end
        access(1, 1, LEN_WORD, 0, 32'h100C, 32'hCAFE_F00D, lat, rd, ex);
        access(1, 0, LEN_WORD, 0, 32'h100C, 32'h0, lat, rd, ex);
        vecs++;
        if (rd !== 32'hCAFE_F00D || ex !== 2'd0) begin
            errs++;
            $display("FAIL rw_top got %h exc=%0d want cafef00d 0", rd, ex);
        end
        access(1, 0, LEN_HALF, 0, 32'h1011, 32'h0, lat, rd, ex);
        vecs++;
        if (ex !== 2'd1) begin
            errs++;
            $display("FAIL mis_over_range got exc=%0d want 1", ex);
        end
    endtask

    task automatic test_back_to_back();
        int lows;
        int pulses;
        int k;
        @(negedge clk);
        k = 0;
        while (!ready_a && k < 50) begin
            @(negedge clk);
            k++;
        end
        req_we = 1'b0;
        req_len = LEN_WORD;
        req_uns = 1'b0;
        req_addr = 32'h10;
        va = 1'b1;
        lows = 0;
        pulses = 0;
        k = 0;
        @(negedge clk);
        while (!ready_a && k < 20) begin
            lows++;
            if (rv_a) pulses++;
            @(negedge clk);
            k++;
        end
        va = 1'b0;
        vecs++;
        if (lows !== 4) begin
            errs++;
            $display("FAIL hold_ready_low got %0d want 4", lows);
        end
        vecs++;
        if (pulses !== 1) begin
            errs++;
            $display("FAIL hold_resp_pulses got %0d want 1", pulses);
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        int pulses;
        logic [31:0] rd;
        logic [1:0] ex;
        @(negedge clk);
        req_we = 1'b1;
        req_len = LEN_WORD;
        req_uns = 1'b0;
        req_addr = 32'h20;
        req_wdata = 32'hDEAD_BEEF;
        va = 1'b1;
        @(posedge clk);
        #1;
        va = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vecs++;
        if (ready_a !== 1'b1) begin
            errs++;
            $display("FAIL abort_ready got %b want 1", ready_a);
        end
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (rv_a) pulses++;
        end
        vecs++;
        if (pulses !== 0) begin
            errs++;
            $display("FAIL abort_resp got %0d want 0", pulses);
        end
        access(0, 0, LEN_WORD, 0, 32'h20, 32'h0, lat, rd, ex);
        vecs++;
        if (rd !== 32'h0 || lat !== 4) begin
            errs++;
            $display("FAIL abort_word got %h lat=%0d want 0 4", rd, lat);
        end
        access(0, 0, LEN_WORD, 0, 32'h10, 32'h0, lat, rd, ex);
        vecs++;
        if (rd !== 32'h0) begin
            errs++;
            $display("FAIL reset_clears got %h want 0", rd);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_range();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired vecs=%0d", vecs);
        $fatal(1, "timeout");
    end

endmodule
